// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank writeback path.
//   REG_ADDR_W : width of a register index (16-entry bank)
//   REG_COUNT  : number of registers in the bank
//   reg_addr_t : register index type
//   wb_state_t : writeback port state (idle / write pending on the bank port)
package regbank_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_COUNT  = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    WB_IDLE,
    WB_WRITE
  } wb_state_t;

endpackage

// File: rtl/regbank_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin arbiter.
// Grants the lowest requesting index at or after the pointer, wrapping mod N.
// Ports:
//   req [N-1:0]     request vector
//   ptr [PTR_W-1:0] highest-priority index (must be < N)
//   gnt [N-1:0]     one-hot grant, all zero when no request
//   idx [PTR_W-1:0] index of the granted requester (0 when none)
//   any             a grant was issued
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int unsigned cand;

  // The inner loop keeps every bit select constant; cand is the rotated
  // position being tried at priority level k.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      for (int unsigned i = 0; i < N; i++) begin
        if (!any && (i == cand) && req[i]) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = PTR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// regbank_wb_arbiter: shares the single write port (WE3/A3/WD3) of the
// 16-entry register bank among N_REQ writeback requesters using round-robin
// arbitration with valid/ready handshakes; one registered write per cycle.
// Optional write-to-read bypass enabled by defining REGBANK_WB_FWD_EN.
// Ports:
//   CLK, RST_N             clock, synchronous active-low reset
//   REQ_VALID [N_REQ]      per-requester write pending
//   REQ_ADDR  [N_REQ*4]    packed destination indices, slice i = [4i+3:4i]
//   REQ_DATA  [N_REQ*BITS] packed write data, slice i = [BITS*i +: BITS]
//   REQ_READY [N_REQ]      one-hot grant (transfer on VALID&READY at posedge)
//   STALL                  blocks new grants
//   WE3, A3, WD3           bank write port (registered)
//   RA1, RA2               bank read addresses
//   RD1_BANK, RD2_BANK     raw bank read data
//   RD1, RD2               read data to consumers (bypassed when enabled)
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned BITS  = 32,
  parameter int unsigned N_REQ = 3
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [N_REQ-1:0]           REQ_VALID,
  input  logic [N_REQ*REG_ADDR_W-1:0] REQ_ADDR,
  input  logic [N_REQ*BITS-1:0]      REQ_DATA,
  output logic [N_REQ-1:0]           REQ_READY,
  input  logic                       STALL,
  output logic                       WE3,
  output logic [REG_ADDR_W-1:0]      A3,
  output logic [BITS-1:0]            WD3,
  input  logic [REG_ADDR_W-1:0]      RA1,
  input  logic [REG_ADDR_W-1:0]      RA2,
  input  logic [BITS-1:0]            RD1_BANK,
  input  logic [BITS-1:0]            RD2_BANK,
  output logic [BITS-1:0]            RD1,
  output logic [BITS-1:0]            RD2
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  wb_state_t        state, state_next;
  logic [PTR_W-1:0] ptr, ptr_next;
  reg_addr_t        a3_q;
  logic [BITS-1:0]  wd3_q;

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             xfer;
  reg_addr_t        sel_addr;
  logic [BITS-1:0]  sel_data;

  // Reset and STALL mask requests before arbitration, so READY depends only
  // on VALID, STALL, RST_N and the pointer.
  assign req_eff = (RST_N && !STALL) ? REQ_VALID : '0;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req_eff),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (xfer)
  );

  assign REQ_READY = gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = REQ_ADDR[REG_ADDR_W*i +: REG_ADDR_W];
        sel_data = REQ_DATA[BITS*i +: BITS];
      end
    end
  end

  always_comb begin
    ptr_next   = ptr;
    state_next = WB_IDLE;
    if (xfer) begin
      state_next = WB_WRITE;
      ptr_next   = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= WB_IDLE;
      ptr   <= '0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      if (xfer) begin
        a3_q  <= sel_addr;
        wd3_q <= sel_data;
      end
    end
  end

  assign WE3 = (state == WB_WRITE);
  assign A3  = a3_q;
  assign WD3 = wd3_q;

`ifdef REGBANK_WB_FWD_EN
  // Bypass the pending bank write to readers of the same register.
  assign RD1 = (WE3 && (a3_q == RA1)) ? wd3_q : RD1_BANK;
  assign RD2 = (WE3 && (a3_q == RA2)) ? wd3_q : RD2_BANK;
`else
  logic [2*REG_ADDR_W-1:0] unused_ra;
  assign unused_ra = {RA1, RA2};
  assign RD1 = RD1_BANK;
  assign RD2 = RD2_BANK;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench for regbank_wb_arbiter (BITS=32, N_REQ=3).
module tb_regbank_wb_arbiter;

  localparam int unsigned BITS = 32;
  localparam int unsigned N    = 3;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [N-1:0]    REQ_VALID;
  logic [N*4-1:0]  REQ_ADDR;
  logic [N*BITS-1:0] REQ_DATA;
  logic [N-1:0]    REQ_READY;
  logic            STALL;
  logic            WE3;
  logic [3:0]      A3;
  logic [BITS-1:0] WD3;
  logic [3:0]      RA1, RA2;
  logic [BITS-1:0] RD1_BANK, RD2_BANK, RD1, RD2;

  always #5 CLK = ~CLK;

  regbank_wb_arbiter #(.BITS(BITS), .N_REQ(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .STALL(STALL), .WE3(WE3),
    .A3(A3), .WD3(WD3), .RA1(RA1), .RA2(RA2), .RD1_BANK(RD1_BANK),
    .RD2_BANK(RD2_BANK), .RD1(RD1), .RD2(RD2)
  );

  typedef struct packed {
    logic [3:0]      a;
    logic [BITS-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  mptr       = 0;

  // Reference round-robin model.
  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] v, input logic rst_n,
                                             input logic stall);
    logic [N-1:0] r;
    r = '0;
    if (rst_n && !stall) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mptr + k) % N;
        if (v[c]) begin
          r[c] = 1'b1;
          return r;
        end
      end
    end
    return r;
  endfunction

  // Record an expected write for the granted requester and advance the model pointer.
  task automatic note_grant(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        wr_t w;
        w.a = REQ_ADDR[4*i +: 4];
        w.d = REQ_DATA[BITS*i +: BITS];
        sb.push_back(w);
        mptr = (i == N - 1) ? 0 : i + 1;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [BITS-1:0] d);
    REQ_ADDR[4*i +: 4]       = a;
    REQ_DATA[BITS*i +: BITS] = d;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    REQ_VALID = '1;
    mptr = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      compared++;
      if (REQ_READY !== '0) begin
        mismatched++;
        $display("FAIL reset_ready cyc%0d: got %b want 000", c, REQ_READY);
      end
      next_cycle();
      compared++;
      if (WE3 !== 1'b0 || A3 !== 4'd0 || WD3 !== '0) begin
        mismatched++;
        $display("FAIL reset_outputs cyc%0d: got we=%b a=%0d wd=%h want 0/0/0", c, WE3, A3, WD3);
      end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    wr_t w;
    RST_N = 1'b1;
    set_req(0, 4'd1, 32'hA);
    set_req(1, 4'd2, 32'hB);
    set_req(2, 4'd3, 32'hC);
    REQ_VALID = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      exp_g = model_gnt(REQ_VALID, RST_N, STALL);
      compared++;
      if (REQ_READY !== exp_g) begin
        mismatched++;
        $display("FAIL contention_grant cyc%0d: got %b want %b", c, REQ_READY, exp_g);
      end
      note_grant(exp_g);
      next_cycle();
      compared++;
      if (WE3 !== 1'b1) begin
        mismatched++;
        $display("FAIL contention_we cyc%0d: got %b want 1", c, WE3);
      end
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL contention_sb cyc%0d: got empty want entry", c);
      end else begin
        w = sb.pop_front();
        compared++;
        if (A3 !== w.a || WD3 !== w.d) begin
          mismatched++;
          $display("FAIL contention_write cyc%0d: got a=%0d wd=%h want a=%0d wd=%h", c, A3, WD3, w.a, w.d);
        end
      end
    end
    REQ_VALID = '0;
    next_cycle();
    compared++;
    if (WE3 !== 1'b0 || A3 !== 4'd3 || WD3 !== 32'hC) begin
      mismatched++;
      $display("FAIL contention_hold: got we=%b a=%0d wd=%h want 0/3/c", WE3, A3, WD3);
    end
    // Pointer back at 0: with 0 and 2 pending, 0 must win.
    REQ_VALID = 3'b101;
    #1;
    compared++;
    if (REQ_READY !== 3'b001) begin
      mismatched++;
      $display("FAIL contention_ptr_wrap: got %b want 001", REQ_READY);
    end
    note_grant(model_gnt(REQ_VALID, RST_N, STALL));
    next_cycle();
    REQ_VALID = '0;
    w = sb.pop_front();
    compared++;
    if (WE3 !== 1'b1 || A3 !== w.a || WD3 !== w.d) begin
      mismatched++;
      $display("FAIL contention_wrap_write: got we=%b a=%0d wd=%h want 1/%0d/%h", WE3, A3, WD3, w.a, w.d);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_g;
    logic         seen2;
    logic         granted;
    wr_t          w;
    seen2 = 1'b0;
    set_req(0, 4'd8, 32'h80);
    set_req(2, 4'd9, 32'h90);
    for (int c = 0; c <= N; c++) begin
      REQ_VALID = (c == 0) ? 3'b001 : 3'b101;
      #1;
      exp_g = model_gnt(REQ_VALID, RST_N, STALL);
      compared++;
      if (REQ_READY !== exp_g) begin
        mismatched++;
        $display("FAIL fairness_grant cyc%0d: got %b want %b", c, REQ_READY, exp_g);
      end
      if (REQ_READY[2] === 1'b1) seen2 = 1'b1;
      granted = |exp_g;
      note_grant(exp_g);
      next_cycle();
      compared++;
      if (WE3 !== granted) begin
        mismatched++;
        $display("FAIL fairness_we cyc%0d: got %b want %b", c, WE3, granted);
      end
      if (granted && sb.size() != 0) begin
        w = sb.pop_front();
        compared++;
        if (A3 !== w.a || WD3 !== w.d) begin
          mismatched++;
          $display("FAIL fairness_write cyc%0d: got a=%0d wd=%h want a=%0d wd=%h", c, A3, WD3, w.a, w.d);
        end
      end
    end
    compared++;
    if (seen2 !== 1'b1) begin
      mismatched++;
      $display("FAIL fairness_starved: got req2_granted=%b want 1", seen2);
    end
    REQ_VALID = '0;
    next_cycle();
    sb.delete();
  endtask

  task automatic test_stall();
    logic [N-1:0] exp_g;
    wr_t w;
    set_req(1, 4'd5, 32'h55);
    REQ_VALID = 3'b010;
    STALL = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      compared++;
      if (REQ_READY !== '0) begin
        mismatched++;
        $display("FAIL stall_ready cyc%0d: got %b want 000", c, REQ_READY);
      end
      next_cycle();
      compared++;
      if (WE3 !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_we cyc%0d: got %b want 0", c, WE3);
      end
    end
    STALL = 1'b0;
    #1;
    exp_g = model_gnt(REQ_VALID, RST_N, STALL);
    compared++;
    if (REQ_READY !== exp_g) begin
      mismatched++;
      $display("FAIL stall_release_ready: got %b want %b", REQ_READY, exp_g);
    end
    note_grant(exp_g);
    next_cycle();
    REQ_VALID = '0;
    w = sb.pop_front();
    compared++;
    if (WE3 !== 1'b1 || A3 !== w.a || WD3 !== w.d) begin
      mismatched++;
      $display("FAIL stall_release_write: got we=%b a=%0d wd=%h want 1/%0d/%h", WE3, A3, WD3, w.a, w.d);
    end
  endtask

  task automatic test_midop_reset();
    wr_t w;
    set_req(0, 4'd6, 32'h66);
    set_req(2, 4'd7, 32'h77);
    REQ_VALID = 3'b001;
    RST_N = 1'b0;
    #1;
    compared++;
    if (REQ_READY !== '0) begin
      mismatched++;
      $display("FAIL midreset_ready: got %b want 000", REQ_READY);
    end
    mptr = 0;
    next_cycle();
    RST_N = 1'b1;
    REQ_VALID = '0;
    compared++;
    if (WE3 !== 1'b0 || A3 !== 4'd0 || WD3 !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs: got we=%b a=%0d wd=%h want 0/0/0", WE3, A3, WD3);
    end
    next_cycle();
    compared++;
    if (WE3 !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_no_pulse: got %b want 0", WE3);
    end
    REQ_VALID = 3'b101;
    #1;
    compared++;
    if (REQ_READY !== 3'b001) begin
      mismatched++;
      $display("FAIL midreset_ptr: got %b want 001", REQ_READY);
    end
    note_grant(model_gnt(REQ_VALID, RST_N, STALL));
    next_cycle();
    REQ_VALID = '0;
    w = sb.pop_front();
    compared++;
    if (WE3 !== 1'b1 || A3 !== w.a || WD3 !== w.d) begin
      mismatched++;
      $display("FAIL midreset_write: got we=%b a=%0d wd=%h want 1/%0d/%h", WE3, A3, WD3, w.a, w.d);
    end
    next_cycle();
  endtask

  task automatic test_forwarding();
    logic [BITS-1:0] exp_rd1;
    wr_t w;
    set_req(0, 4'd4, 32'h1234);
    REQ_VALID = 3'b001;
    #1;
    note_grant(model_gnt(REQ_VALID, RST_N, STALL));
    next_cycle();
    REQ_VALID = '0;
    RA1 = 4'd4;
    RD1_BANK = '0;
    RA2 = 4'd7;
    RD2_BANK = 32'hBEEF;
    #1;
    w = sb.pop_front();
    compared++;
    if (WE3 !== 1'b1 || A3 !== w.a || WD3 !== w.d) begin
      mismatched++;
      $display("FAIL fwd_write: got we=%b a=%0d wd=%h want 1/%0d/%h", WE3, A3, WD3, w.a, w.d);
    end
`ifdef REGBANK_WB_FWD_EN
    exp_rd1 = 32'h1234;
`else
    exp_rd1 = 32'h0;
`endif
    compared++;
    if (RD1 !== exp_rd1) begin
      mismatched++;
      $display("FAIL fwd_rd1: got %h want %h", RD1, exp_rd1);
    end
    compared++;
    if (RD2 !== 32'hBEEF) begin
      mismatched++;
      $display("FAIL fwd_rd2: got %h want beef", RD2);
    end
    RD1_BANK = 32'h77;
    next_cycle();
    compared++;
    if (RD1 !== 32'h77) begin
      mismatched++;
      $display("FAIL fwd_idle_rd1: got %h want 77", RD1);
    end
  endtask

  initial begin
    RST_N     = 1'b0;
    REQ_VALID = '0;
    REQ_ADDR  = '0;
    REQ_DATA  = '0;
    STALL     = 1'b0;
    RA1       = '0;
    RA2       = '0;
    RD1_BANK  = '0;
    RD2_BANK  = '0;
    test_reset();
    test_contention();
    test_fairness();
    test_stall();
    test_midop_reset();
    test_forwarding();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
